regfile_operand_stage: RTL
==========================

Name: regfile_operand_stage

Overview:
- Upstream neighbour of the ALU: 32x32 MIPS register file plus a registered operand latch.
- Drives the ALU's a, b and 2-bit sel inputs from two read ports; one write port receives writeback.
- The operand latch supports stall (hold) and flush (bubble), so the ALU sees stable, pipeline-aligned operands.

Parameters:
- DATA_W, 32, register and operand width
- ADDR_W, 5, register address width (2**ADDR_W registers)
- SEL_W, 2, ALU operation select width, passed through to the ALU sel input

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- raddr_a  input  ADDR_W  source register for operand a
- raddr_b  input  ADDR_W  source register for operand b
- sel_in  input  SEL_W  ALU op for this instruction (0 add, 1 sub, 2/3 per ALU)
- valid_in  input  1  instruction present at the inputs this cycle
- stall  input  1  hold the operand latch
- flush  input  1  kill the latched instruction (insert bubble)
- we  input  1  writeback enable
- waddr  input  ADDR_W  writeback register
- wdata  input  DATA_W  writeback data
- a  output  DATA_W  registered operand a to ALU
- b  output  DATA_W  registered operand b to ALU
- sel  output  SEL_W  registered ALU select
- valid_out  output  1  a/b/sel hold a live instruction

Behaviour:
- Reset (rst=1 at a rising edge): all registers, including r0, cleared to 0; a=0, b=0, sel=0, valid_out=0. Any write requested in the same cycle is dropped.
- Register array: write on the rising edge when we=1 and waddr!=0. Writes to r0 are discarded; a read of r0 always returns 0.
- Writes are independent of stall and flush and always occur.
- Read latency: 1 cycle.
  - If stall=0 and flush=0, at the edge: a <= R[raddr_a], b <= R[raddr_b], sel <= sel_in, valid_out <= valid_in.
  - a and b are latched even when valid_in=0. Their contents are don't-care while valid_out=0.
- Stall (stall=1, flush=0): a, b, sel and valid_out hold their values.
  - A write during a stall to a register already latched does NOT update a or b.
  - The pipeline controller re-issues after the stall if a refresh is needed.
- Flush (flush=1): at the edge a=0, b=0, sel=0, valid_out=0. Flush has priority over stall.
- Priority order: rst > flush > stall > normal capture.
- Same-cycle read/write of the same nonzero register: behaviour is set by the optional feature below.
- Address width: the full ADDR_W is decoded; there is no aliasing.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: on a normal capture, if we=1, waddr!=0 and waddr==raddr_a (or raddr_b), the latch takes wdata instead of the old array value (write-through). Each port is checked independently; both ports may bypass in the same cycle.
- Not defined: the latch takes the pre-write array value. The new value becomes visible to reads issued the following cycle.
- Bypass never applies to r0, and never applies while stall or flush is active.

Test Plan:
- Reset then read: rst=1 for 2 cycles, then raddr_a=7, raddr_b=31, valid_in=1 -> a=0, b=0, valid_out=1 one cycle later.
- Write then read: write R5=5001 and R6=3001 on consecutive cycles; next cycle raddr_a=5, raddr_b=6, sel_in=1 -> a=5001, b=3001, sel=1; ALU out=2000.
- r0 protection: we=1, waddr=0, wdata=32'hFFFFFFFF; then read raddr_a=0 -> a=0.
- Same-cycle hazard: R9=1 held; issue we=1, waddr=9, wdata=32'h00000002 together with raddr_a=9 -> a=2 with REGFILE_BYPASS_EN defined, a=1 without; the next read of R9 returns 2 in both builds.
- Stall/flush: latch a=8006001, b=8002, sel=0, then stall=1 for 3 cycles with new raddr/sel_in and a write to the source register -> outputs unchanged. Then assert flush and stall together -> a=0, b=0, sel=0, valid_out=0.
- Mid-operation reset: with valid_out=1, a=32'hFFFFFFFF, assert rst together with we=1, waddr=3 -> next cycle all outputs are 0 and a later read of R3 returns 0.

Source files
------------

// File: rtl/regfile_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : regfile_operand_stage
// Description : 32x32 MIPS-style register file feeding a registered operand
//               latch (a, b, sel, valid_out) that drives the ALU. The latch
//               supports stall (hold) and flush (bubble). The single write
//               port takes writeback data independently of stall and flush.
// Options     : REGFILE_BYPASS_EN - when defined, a normal capture that reads
//               the register being written this cycle takes wdata
//               (write-through) instead of the pre-write array value.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_operand_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int SEL_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  input  logic [SEL_W-1:0]  sel_in,
  input  logic              valid_in,
  input  logic              stall,
  input  logic              flush,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [SEL_W-1:0]  sel,
  output logic              valid_out
);

  localparam int c_NREG = 1 << ADDR_W;

  // Register array. Entry 0 is reset like the others and never written, so it
  // stays zero; reads of address 0 are also forced to zero below.
  logic [DATA_W-1:0] r_mem [c_NREG];

  logic              w_wr_en;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;
  logic              w_byp_a;
  logic              w_byp_b;
  logic [DATA_W-1:0] w_op_a;
  logic [DATA_W-1:0] w_op_b;

  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [SEL_W-1:0]  r_sel;
  logic              r_valid;

  // A write to r0 is discarded; a write in a reset cycle is dropped by the
  // reset branch of the array process.
  assign w_wr_en = we && (waddr != '0);

  // Writeback into the array; independent of stall and flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_NREG; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Asynchronous array reads with r0 hardwired to zero.
  always_comb begin
    w_rd_a = '0;
    w_rd_b = '0;
    if (raddr_a != '0) begin
      w_rd_a = r_mem[raddr_a];
    end
    if (raddr_b != '0) begin
      w_rd_b = r_mem[raddr_b];
    end
  end

  // Same-cycle read/write hazard resolution. The bypass select only matters
  // on a normal capture, which is the only time the operand mux is sampled;
  // w_wr_en already excludes r0.
  always_comb begin
    w_byp_a = 1'b0;
    w_byp_b = 1'b0;
`ifdef REGFILE_BYPASS_EN
    w_byp_a = w_wr_en && (waddr == raddr_a);
    w_byp_b = w_wr_en && (waddr == raddr_b);
`else
    w_byp_a = 1'b0;
    w_byp_b = 1'b0;
`endif
    w_op_a = w_byp_a ? wdata : w_rd_a;
    w_op_b = w_byp_b ? wdata : w_rd_b;
  end

  // Operand latch: reset > flush > stall > capture. Operands are captured even
  // when valid_in is low; they are meaningless while valid_out is low.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
    end else if (!stall) begin
      r_a     <= w_op_a;
      r_b     <= w_op_b;
      r_sel   <= sel_in;
      r_valid <= valid_in;
    end
  end

  assign a         = r_a;
  assign b         = r_b;
  assign sel       = r_sel;
  assign valid_out = r_valid;

endmodule
`default_nettype wire
